// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 2-flop synchroniser, irq pulse, frame-error and busy status.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 (8E1).
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_rx,
  output logic       o_irq,
  output logic       o_frame_err,
  output logic       o_rx_busy
);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) >> 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  state_t           state_q, state_d;
  logic             sync_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d, rx_q, rx_d;
  logic             irq_q, irq_d, ferr_q, ferr_d, par_err;
  logic             tick;
  assign tick = cnt_q == FULL;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    irq_d   = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (!rxs_q) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (cnt_q == HALF) begin
        state_d = rxs_q ? IDLE : DATA;
        cnt_d   = '0;
        idx_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      DATA: if (tick) begin
        shift_d[idx_q] = rxs_q;
        cnt_d          = '0;
        idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d        = idx_q == 3'd7 ? PARITY : DATA;
`else
        state_d        = idx_q == 3'd7 ? STOP : DATA;
`endif
      end else cnt_d = cnt_q + CNT_W'(1);
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_d   = ^shift_q ^ rxs_q;
        cnt_d   = '0;
        state_d = STOP;
      end else cnt_d = cnt_q + CNT_W'(1);
`endif
      // Leaving at mid-stop-bit lets a start edge at the end of the stop bit be caught.
      STOP: if (tick) begin
        rx_d    = shift_q;
        irq_d   = 1'b1;
        ferr_d  = !rxs_q | par_err;
        cnt_d   = '0;
        state_d = rxs_q ? IDLE : BREAK;
      end else cnt_d = cnt_q + CNT_W'(1);
      BREAK: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      irq_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= i_rxd;
      rxs_q   <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      irq_q   <= irq_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign o_rx        = rx_q;
  assign o_irq       = irq_q;
  assign o_frame_err = ferr_q;
  assign o_rx_busy   = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with a scoreboard queue checked by an irq-driven monitor.
module tb_uart_rx_core;
  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + (C - 1) / 2 + 10 * C;
`else
  localparam int LAT = 3 + (C - 1) / 2 + 9 * C;
`endif
  logic clk = 1'b0, rst = 1'b1, i_rxd = 1'b1;
  logic [7:0] o_rx;
  logic o_irq, o_frame_err, o_rx_busy;
  uart_rx_core #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_rxd(i_rxd),
    .o_rx(o_rx), .o_irq(o_irq), .o_frame_err(o_frame_err), .o_rx_busy(o_rx_busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         t0;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, irqs = 0, n_exp = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_irq) begin
      irqs++;
      chk("irq_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rx_byte", o_rx, e.d);
        chk("frame_err", o_frame_err, e.fe);
        chk("irq_latency", cyc - e.t0, LAT);
      end
    end
  end
  task automatic bitp(input logic b);
    i_rxd = b;
    repeat (C) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    exp_t e;
`ifdef UART_RX_PARITY_EN
    e = '{d, !stop | flip, cyc + 1};
`else
    e = '{d, !stop, cyc + 1};
`endif
    q.push_back(e);
    n_exp++;
    i_rxd = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_start", o_rx_busy, 1);
    repeat (C - 4) @(negedge clk);
    for (int i = 0; i < 8; i++) bitp(d[i]);
`ifdef UART_RX_PARITY_EN
    bitp(^d ^ flip);
`endif
    bitp(stop);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reset_rx", o_rx, 0);
    chk("reset_irq", o_irq, 0);
    chk("reset_ferr", o_frame_err, 0);
    chk("reset_busy", o_rx_busy, 0);
    rst = 1'b0;
    repeat (4 * C) @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("busy_after_frame", o_rx_busy, 0);
    repeat (2 * C) @(negedge clk);
    n = irqs;
    i_rxd = 1'b0;
    repeat (2) @(negedge clk);
    i_rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy", o_rx_busy, 0);
    chk("glitch_rx_kept", o_rx, 8'hA5);
    chk("glitch_no_irq", irqs, n);
    n = irqs;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * C) @(negedge clk);
    chk("break_single_irq", irqs, n + 1);
    chk("break_busy", o_rx_busy, 1);
    i_rxd = 1'b1;
    repeat (2 * C) @(negedge clk);
    chk("break_released", o_rx_busy, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (2 * C) @(negedge clk);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (2 * C) @(negedge clk);
    n = irqs;
    i_rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) bitp(1'(8'h96 >> i));
    i_rxd = 1'b0;
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rx", o_rx, 0);
    chk("midrst_irq", o_irq, 0);
    chk("midrst_ferr", o_frame_err, 0);
    chk("midrst_busy", o_rx_busy, 0);
    i_rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3 * C) @(negedge clk);
    chk("midrst_no_irq", irqs, n);
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (2 * C) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (2 * C) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (2 * C) @(negedge clk);
`endif
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("irq_count", irqs, n_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
